// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM, UART TX FIFO,
// RX holding register, free-running cycle counter and program-stop flag.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_W  = 17,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(TX_DEPTH - FULL_MARGIN);
  localparam logic [2:0] OFF_UART = 3'd0;
  localparam logic [2:0] OFF_CNT0 = 3'd4;
  localparam logic [2:0] OFF_CNT1 = 3'd5;
  localparam logic [2:0] OFF_CNT2 = 3'd6;
  localparam logic [2:0] OFF_CNT3 = 3'd7;

  logic [7:0]       ram    [RAM_BYTES];
  logic [7:0]       fifo_q [TX_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_din_q, mem_din_d;
  logic [7:0]       rx_hold_q, rx_hold_d;
  logic             rx_full_q, rx_full_d;
  logic [31:0]      counter_q;
  logic [31:0]      snap_q, snap_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic                  sel_ram;
  logic                  sel_io;
  logic [2:0]            io_off;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  io_wr;
  logic                  io_rd;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  rx_load;
  logic [7:0]            push_data;
  logic [7:0]            rd_data;
  logic                  unused_addr;

  // Address decode: 00/01 RAM, 10 hole, 11 I/O (offset in the low three bits)
  assign sel_ram     = ~mem_a[17];
  assign sel_io      = &mem_a[17:16];
  assign io_off      = mem_a[2:0];
  assign ram_addr    = mem_a[RAM_ADDR_W-1:0];
  assign unused_addr = ^mem_a[31:18];

  // Once stopped, the I/O map ignores writes; reads stay live
  assign io_wr     = mem_wr & sel_io & ~done_q;
  assign io_rd     = ~mem_wr & sel_io;
  assign push_req  = io_wr & (((io_off == OFF_UART) & (mem_dout != 8'h00)) |
                              (io_off == OFF_CNT0));
  assign push_data = (io_off == OFF_CNT0) ? 8'h00 : mem_dout;
  assign push_ok   = push_req & (count_q != DEPTH_C);
  assign pop       = tx_valid & tx_ready;
  assign rx_load   = rx_valid & ~rx_full_q;

  always_comb begin
    rd_data = 8'h00;
    if (sel_ram) begin
      rd_data = ram[ram_addr];
    end else if (sel_io) begin
      case (io_off)
        OFF_UART: rd_data = rx_full_q ? rx_hold_q : 8'h00;
        OFF_CNT0: rd_data = counter_q[7:0];
        OFF_CNT1: rd_data = snap_q[15:8];
        OFF_CNT2: rd_data = snap_q[23:16];
        OFF_CNT3: rd_data = snap_q[31:24];
        default:  rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    mem_din_d = mem_wr ? mem_din_q : rd_data;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    ovf_d     = ovf_q | (push_req & ~push_ok);
    done_d    = done_q | (io_wr & (io_off == OFF_CNT0));
    snap_d    = (io_rd && (io_off == OFF_CNT0)) ? counter_q : snap_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    if (io_rd && (io_off == OFF_UART)) begin
      rx_full_d = 1'b0;
    end
    // A load only happens into an empty register, so a coincident read sees 0x00
    if (rx_load) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_hold_q <= 8'h00;
      rx_full_q <= 1'b0;
      counter_q <= 32'h0;
      snap_q    <= 32'h0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
      counter_q <= counter_q + 32'd1;
      snap_q    <= snap_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by pointers/count
  always_ff @(posedge clk_in) begin
    if (mem_wr && sel_ram) begin
      ram[ram_addr] <= mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  assign mem_din        = mem_din_q;
  assign io_buffer_full = (count_q >= FULL_LVL);
  assign tx_data        = fifo_q[rd_ptr_q];
  assign tx_valid       = (count_q != '0);
  assign rx_ready       = ~rx_full_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised scoreboard bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = 32'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_done;
  logic        tx_overflow;

  mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_done(program_done), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0]  ram_m [logic [16:0]];
  logic [7:0]  exp_tx [$];
  int          tx_cnt_m;
  bit          ovf_m, done_m, rxf_m;
  logic [7:0]  rx_m;
  logic [31:0] cnt_m, snap_m;

  logic [7:0]  rd_exp [$];
  bit          rd_chk [$];
  logic [4:0]  st_exp [$];
  bit          mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] pool [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, advance the model, queue expectations
  task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic txr, input logic [7:0] rxd, input logic rxv);
    logic [7:0] rv, pd;
    bit chk, rd_rx, push, pop, load, full_e;
    int pre;
    mem_a = a; mem_wr = wr; mem_dout = d; tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    full_e = (tx_cnt_m >= DEPTH - MARGIN);
    st_exp.push_back({full_e, tx_cnt_m != 0, !rxf_m, done_m, ovf_m});

    rv = 8'h00; chk = 1; rd_rx = 0; push = 0; pd = 8'h00;
    if (!wr) begin
      if (a[17:16] != 2'b10 && a[17:16] != 2'b11) begin
        if (ram_m.exists(a[16:0])) rv = ram_m[a[16:0]];
        else chk = 0;
      end else if (a[17:16] == 2'b11) begin
        case (a[2:0])
          3'd0: begin rv = rxf_m ? rx_m : 8'h00; rd_rx = 1; end
          3'd4: begin rv = cnt_m[7:0]; snap_m = cnt_m; end
          3'd5: rv = snap_m[15:8];
          3'd6: rv = snap_m[23:16];
          3'd7: rv = snap_m[31:24];
          default: rv = 8'h00;
        endcase
      end
      rd_exp.push_back(rv);
      rd_chk.push_back(chk);
    end else begin
      if (a[17] == 1'b0) ram_m[a[16:0]] = d;
      else if (a[17:16] == 2'b11 && !done_m) begin
        if (a[2:0] == 3'd0 && d != 8'h00) begin push = 1; pd = d; end
        if (a[2:0] == 3'd4) begin push = 1; pd = 8'h00; done_m = 1; end
      end
    end

    pre = tx_cnt_m;
    pop = (pre != 0) && txr;
    if (push) begin
      if (pre == DEPTH) ovf_m = 1;
      else begin exp_tx.push_back(pd); tx_cnt_m++; end
    end
    if (pop) tx_cnt_m--;

    load = rxv && !rxf_m;
    if (rd_rx) rxf_m = 0;
    if (load) begin rxf_m = 1; rx_m = rxd; end

    cnt_m++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) cycle(32'h0002_0000, 1'b0, 8'h00, txr, 8'h00, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    mon_en = 0;
    rst_in = 1'b0;
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_program_done", 32'(program_done), 32'd0);
    check("rst_tx_overflow", 32'(tx_overflow), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_io_buffer_full", 32'(io_buffer_full), 32'd0);
    exp_tx.delete(); rd_exp.delete(); rd_chk.delete(); st_exp.delete();
    tx_cnt_m = 0; ovf_m = 0; done_m = 0; rxf_m = 0; rx_m = 8'h00; snap_m = 32'h0;
    mem_wr = 1'b0; mem_a = 32'h0002_0000; tx_ready = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    cnt_m = 32'd1;
    mon_en = 1;
  endtask

  initial begin : monitor
    bit rd_pend;
    rd_pend = 0;
    forever begin
      @(negedge clk_in);
      if (!mon_en) begin
        rd_pend = 0;
      end else begin
        if (rd_pend) begin
          if (rd_exp.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd_queue: read completed with no expected value at %0t", $time);
          end else begin
            logic [7:0] ev;
            bit ec;
            ev = rd_exp.pop_front();
            ec = rd_chk.pop_front();
            if (ec) check("mem_din", 32'(mem_din), 32'(ev));
          end
        end
        rd_pend = !mem_wr;
        if (st_exp.size() != 0)
          check("status{full,valid,rx_ready,done,ovf}",
                32'({io_buffer_full, tx_valid, rx_ready, program_done, tx_overflow}),
                32'(st_exp.pop_front()));
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL tx_unexpected: got 0x%0h expected none at %0t", tx_data, $time);
          end else begin
            check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [7:0]  d;
    int kind;
    #1;
    do_reset();

    // RAM write then read-back
    cycle(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // "H", zero, "i" with the UART draining
    cycle(32'h0003_0000, 1'b1, 8'h48, 1'b1, 8'h00, 1'b0);
    cycle(32'h0003_0000, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    cycle(32'h0003_0000, 1'b1, 8'h69, 1'b1, 8'h00, 1'b0);
    idle(4, 1'b1);

    // Fill to overflow with the UART stalled, then drain
    for (int i = 0; i < 9; i++) cycle(32'h0003_0000, 1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);

    // Simultaneous push/pop at depth 3, wrapping the pointers
    for (int i = 0; i < 3; i++) cycle(32'h0003_0000, 1'b1, 8'(8'h20 + i), 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cycle(32'h0003_0000, 1'b1, 8'(8'h80 + i), 1'b1, 8'h00, 1'b0);
    idle(5, 1'b1);
    check("tx_drained_1", 32'(exp_tx.size()), 32'd0);

    // RX holding register
    cycle(32'h0002_0000, 1'b0, 8'h00, 1'b0, 8'h37, 1'b1);
    cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b1);
    cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b1);
    cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Counter snapshot read at 0xFF, plus hole and unused offsets
    do_reset();
    while (cnt_m != 32'hFF) idle(1, 1'b0);
    for (int i = 4; i < 8; i++) cycle(32'h0003_0000 | 32'(i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(32'h0003_0005, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    cycle(32'h0003_0002, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(32'h0002_1234, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
    cycle(32'h0002_1234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Random traffic over a known RAM pool, the hole and the I/O map
    for (int i = 0; i < 16; i++) begin
      pool[i] = 17'((i * 32'h2345 + 32'h400) & 32'h1FFFF);
      cycle({15'h0, pool[i]}, 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    end
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 9));
      a = {14'($urandom), 18'h0};
      d = 8'($urandom);
      if (kind <= 3) begin
        a = a | {15'h0, pool[$urandom_range(0, 15)]};
      end else if (kind == 4) begin
        a = a | 32'h0002_0000 | 32'($urandom_range(0, 16'hFFFF));
      end else if (kind <= 8) begin
        a = a | 32'h0003_0000;
        if ($urandom_range(0, 7) == 0) d = 8'h00;
      end else begin
        a = a | 32'h0003_0000 | 32'($urandom_range(1, 7));
      end
      if (kind == 9 && a[2:0] == 3'd4) begin
        cycle(a, 1'b0, d, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      end else begin
        cycle(a, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 3) != 0),
              8'($urandom), 1'($urandom_range(0, 3) == 0));
      end
    end
    idle(12, 1'b1);
    check("tx_drained_2", 32'(exp_tx.size()), 32'd0);

    // Program stop, then a write that must be ignored
    cycle(32'h0003_0004, 1'b1, 8'h5E, 1'b1, 8'h00, 1'b0);
    idle(3, 1'b1);
    cycle(32'h0003_0000, 1'b1, 8'h41, 1'b1, 8'h00, 1'b0);
    idle(3, 1'b1);
    check("tx_drained_3", 32'(exp_tx.size()), 32'd0);

    // Reset in the middle of a drain (program_done still set)
    cycle(32'h0000_0010, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(32'h0003_0000, 1'b1, 8'(8'h61 + i), 1'b0, 8'h00, 1'b0);
    idle(2, 1'b1);
    do_reset();
    cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(32'h0003_0000, 1'b1, 8'h42, 1'b1, 8'h00, 1'b0);
    idle(4, 1'b1);
    mon_en = 0;
    check("tx_drained_final", 32'(exp_tx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
